// File: rtl/point_cloud_buffer_pkg.sv
// point_cloud_buffer_pkg: shared point type and buffer state encoding
package point_cloud_buffer_pkg;
  typedef enum logic [1:0] {IDLE, LOADING, READY} buffer_state_t;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } point_t;
  localparam int POINT_W = $bits(point_t);
endpackage

// File: rtl/point_read_pipe.sv
// point_read_pipe: range check, out-of-range substitution and fixed-latency response delay line
module point_read_pipe
  import point_cloud_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1,
  parameter int OOR_MODE     = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                enable,
  input  logic                req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH:0] stored_count,
  input  logic [POINT_W-1:0]  mem_point,
  input  logic [POINT_W-1:0]  last_point,
  output logic                rsp_valid,
  output logic [POINT_W-1:0]  rsp_point,
  output logic                rsp_oor
);
  logic take, oor;
  logic [POINT_W-1:0] pick;
  logic [READ_LATENCY-1:0] v_q, o_q;
  logic [POINT_W-1:0] d_q [READ_LATENCY];
  assign take = req_valid & enable & ~flush;
  assign oor = {1'b0, req_addr} >= stored_count;
  assign pick = !oor ? mem_point : (OOR_MODE != 0) ? last_point : '0;
  // data is zeroed alongside valid so idle outputs read as zero
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      v_q <= '0;
      o_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= take;
      o_q[0] <= take & oor;
      d_q[0] <= take ? pick : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= v_q[i-1] & ~flush;
        o_q[i] <= o_q[i-1] & ~flush;
        d_q[i] <= flush ? '0 : d_q[i-1];
      end
    end
  assign rsp_valid = v_q[READ_LATENCY-1];
  assign rsp_oor   = o_q[READ_LATENCY-1];
  assign rsp_point = d_q[READ_LATENCY-1];
endmodule

// File: rtl/point_cloud_buffer.sv
// point_cloud_buffer: streamed point-cloud store with multi-port fixed-latency reads
module point_cloud_buffer
  import point_cloud_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 9,
  parameter int MAX_POINTS   = 1 << ADDR_WIDTH,
  parameter int READ_PORTS   = 1,
  parameter int READ_LATENCY = 1,
  parameter int MIN_POINTS   = 3,
  parameter int OOR_MODE     = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load_start,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [POINT_W-1:0]               load_point,
  input  logic                             load_last,
  output logic [ADDR_WIDTH:0]              stored_count,
  output logic                             buffer_ready,
  output logic                             overflow,
  input  logic [READ_PORTS-1:0]            rd_addr_valid,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [READ_PORTS-1:0]            rd_data_valid,
  output logic [READ_PORTS*POINT_W-1:0]    rd_data,
  output logic [READ_PORTS-1:0]            rd_out_of_range
);
  buffer_state_t state, state_d;
  logic [ADDR_WIDTH:0] count_d;
  logic beat, store;
  point_t mem [MAX_POINTS];
  point_t last_point;
  assign load_ready = state == LOADING;
  assign beat = load_valid & load_ready & ~load_start;
  assign store = beat & (stored_count < (ADDR_WIDTH+1)'(MAX_POINTS));
  always_comb state_d = load_start ? LOADING : (beat & load_last) ? READY : state;
  always_comb count_d = load_start ? '0 : store ? stored_count + (ADDR_WIDTH+1)'(1) : stored_count;
  always_comb last_point = (stored_count == '0) ? '0 : mem[ADDR_WIDTH'(stored_count - (ADDR_WIDTH+1)'(1))];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      stored_count <= '0;
      overflow     <= 1'b0;
      buffer_ready <= 1'b0;
    end else begin
      state        <= state_d;
      stored_count <= count_d;
      overflow     <= load_start ? 1'b0 : overflow | (beat & ~store);
      buffer_ready <= (state_d == READY) & (count_d >= (ADDR_WIDTH+1)'(MIN_POINTS));
    end
  always_ff @(posedge clock)
    if (store) mem[stored_count[ADDR_WIDTH-1:0]] <= load_point;
  // load_start flushes every port so stale responses never outlive their cloud
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    point_read_pipe #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .READ_LATENCY(READ_LATENCY),
      .OOR_MODE    (OOR_MODE)
    ) u_pipe (
      .clock       (clock),
      .reset       (reset),
      .flush       (load_start),
      .enable      (state == READY),
      .req_valid   (rd_addr_valid[p]),
      .req_addr    (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .stored_count(stored_count),
      .mem_point   (mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]),
      .last_point  (last_point),
      .rsp_valid   (rd_data_valid[p]),
      .rsp_point   (rd_data[p*POINT_W +: POINT_W]),
      .rsp_oor     (rd_out_of_range[p])
    );
  end
endmodule

// File: tb/tb_point_cloud_buffer.sv
// tb_point_cloud_buffer: directed+random checks of two buffers (zero and last-point out-of-range policy)
module tb_point_cloud_buffer;
  localparam int AW = 3;
  localparam int PW = 48;
  logic clock = 1'b0;
  logic reset, load_start, load_valid, load_last;
  logic [PW-1:0] load_point;
  logic [1:0] rd_addr_valid;
  logic [2*AW-1:0] rd_addr;
  logic lr [2];
  logic br [2];
  logic ov [2];
  logic [AW:0] cnt [2];
  logic [1:0] dv [2];
  logic [1:0] oo [2];
  logic [2*PW-1:0] dd [2];
  int checks = 0;
  int failures = 0;
  logic [PW-1:0] mdl [8];
  int m_cnt = 0;
  int m_ovf = 0;
  int m_st = 0;
  logic ev [64][2];
  logic eo [64][2];
  logic [PW-1:0] ed [64][2][2];

  always #5 clock = ~clock;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    point_cloud_buffer #(
      .ADDR_WIDTH(AW), .MAX_POINTS(8), .READ_PORTS(2),
      .READ_LATENCY(2), .MIN_POINTS(3), .OOR_MODE(m)
    ) dut (
      .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
      .load_ready(lr[m]), .load_point(load_point), .load_last(load_last),
      .stored_count(cnt[m]), .buffer_ready(br[m]), .overflow(ov[m]),
      .rd_addr_valid(rd_addr_valid), .rd_addr(rd_addr), .rd_data_valid(dv[m]),
      .rd_data(dd[m]), .rd_out_of_range(oo[m])
    );
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_count"}, 64'(cnt[m]), 64'(m_cnt));
      chk({tag, "_ready"}, 64'(br[m]), 64'(m_st == 2 && m_cnt >= 3));
      chk({tag, "_overflow"}, 64'(ov[m]), 64'(m_ovf));
      chk({tag, "_load_ready"}, 64'(lr[m]), 64'(m_st == 1));
    end
  endtask

  task automatic load_cloud(int n);
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    m_cnt = 0;
    m_ovf = 0;
    m_st = 1;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_point = PW'({$urandom(), $urandom()});
      load_last = (i == n - 1);
      step;
      if (m_cnt < 8) begin
        mdl[m_cnt] = load_point;
        m_cnt++;
      end else m_ovf = 1;
      if (load_last) m_st = 2;
    end
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  // mode 0: random, 1: sweep (port1 descending), 2: fixed a0/a1
  task automatic read_burst(int n, int mode, int a0, int a1);
    int a;
    for (int k = 0; k <= n; k++) begin
      for (int p = 0; p < 2; p++) begin
        a = (mode == 0) ? int'($urandom_range(0, 7)) :
            (mode == 1) ? ((p == 0) ? k % 8 : 7 - k % 8) : ((p == 0) ? a0 : a1);
        rd_addr[p*AW +: AW] = AW'(a);
        rd_addr_valid[p] = (k < n) && (mode != 0 || $urandom_range(0, 3) != 0);
        ev[k][p] = rd_addr_valid[p] && m_st == 2;
        eo[k][p] = ev[k][p] && a >= m_cnt;
        ed[k][p][0] = (ev[k][p] && !eo[k][p]) ? mdl[a] : '0;
        ed[k][p][1] = !ev[k][p] ? '0 : !eo[k][p] ? mdl[a] : (m_cnt > 0) ? mdl[m_cnt-1] : '0;
      end
      step;
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < 2; p++)
          if (k == 0) chk("rd_valid_early", 64'(dv[m][p]), 64'(0));
          else begin
            chk("rd_valid", 64'(dv[m][p]), 64'(ev[k-1][p]));
            chk("rd_oor", 64'(oo[m][p]), 64'(eo[k-1][p]));
            chk(m == 0 ? "rd_data_mode0" : "rd_data_mode1", 64'(dd[m][p*PW +: PW]), 64'(ed[k-1][p][m]));
          end
    end
    rd_addr_valid = '0;
  endtask

  initial begin
    reset = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    load_point = '0;
    rd_addr_valid = '0;
    rd_addr = '0;
    #3;
    chk_status("reset");
    for (int m = 0; m < 2; m++) chk("reset_rd_valid", 64'(dv[m]), 64'(0));
    #4 reset = 1'b1;
    step;
    load_cloud(5);
    chk_status("load5");
    read_burst(1, 2, 1, 4);
    read_burst(1, 2, 7, 5);
    read_burst(24, 0, 0, 0);
    load_cloud(10);
    chk_status("load10_overflow");
    read_burst(8, 1, 0, 0);
    read_burst(20, 0, 0, 0);
    load_cloud(2);
    chk_status("load2");
    read_burst(3, 0, 0, 0);
    read_burst(1, 2, 1, 3);
    // load_start squashes responses already in flight
    rd_addr_valid = 2'b11;
    rd_addr = {3'(1), 3'(0)};
    step;
    rd_addr_valid = '0;
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    m_st = 1;
    m_cnt = 0;
    m_ovf = 0;
    for (int m = 0; m < 2; m++) chk("squash_a", 64'(dv[m]), 64'(0));
    step;
    for (int m = 0; m < 2; m++) chk("squash_b", 64'(dv[m]), 64'(0));
    chk_status("after_squash");
    // restart in LOADING with a simultaneous beat: the beat is discarded
    load_start = 1'b1;
    load_valid = 1'b1;
    load_point = PW'({$urandom(), $urandom()});
    step;
    load_start = 1'b0;
    chk_status("restart_beat_dropped");
    read_burst(2, 0, 0, 0);
    step;
    step;
    load_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    m_st = 0;
    m_cnt = 0;
    m_ovf = 0;
    chk_status("async_reset");
    for (int m = 0; m < 2; m++) begin
      chk("async_reset_rd_valid", 64'(dv[m]), 64'(0));
      chk("async_reset_rd_data", 64'(dd[m]), 64'(0));
      chk("async_reset_rd_oor", 64'(oo[m]), 64'(0));
    end
    #1 reset = 1'b1;
    step;
    chk_status("idle_after_reset");
    read_burst(4, 0, 0, 0);
    load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    chk_status("idle_beat_ignored");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
